// File: rtl/tohost_monitor.sv
// Snoops the core's store path for the riscv-tests tohost word and reports sticky pass/fail/timeout status.
// Optional feature: define TOHOST_WATCHDOG_EN to enable the cycle watchdog and TIMEOUT state.
module tohost_monitor #(
  parameter logic [31:0] TOHOST_ADDR    = 32'h0000_1000,
  parameter int unsigned WATCHDOG_TICKS = 6000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wmask,
  output logic        done,
  output logic        pass,
  output logic [30:0] fail_id,
  output logic        timeout,
  output logic [31:0] cycle_count
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DONE    = 2'd1,
    TIMEOUT = 2'd2
  } state_t;

  localparam logic [31:0] EXPIRE_COUNT = 32'(WATCHDOG_TICKS - 1);

`ifdef TOHOST_WATCHDOG_EN
  localparam bit WATCHDOG_EN = 1'b1;
`else
  localparam bit WATCHDOG_EN = 1'b0;
`endif

  state_t state;
  logic   accept;
  logic   expire;

  // Only full-word odd writes terminate the test; even values are syscall/clear traffic.
  assign accept = mem_we && (mem_addr == TOHOST_ADDR) && (mem_wmask == 4'hF) && mem_wdata[0];
  assign expire = WATCHDOG_EN && (cycle_count == EXPIRE_COUNT);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      pass        <= 1'b0;
      fail_id     <= '0;
      cycle_count <= '0;
    end else begin
      case (state)
        RUN: begin
          if (cycle_count != 32'hFFFF_FFFF) cycle_count <= cycle_count + 32'd1;
          // A store in the expiry cycle takes priority over the watchdog.
          if (accept) begin
            state   <= DONE;
            pass    <= (mem_wdata == 32'd1);
            fail_id <= (mem_wdata == 32'd1) ? 31'd0 : mem_wdata[31:1];
          end else if (expire) begin
            state <= TIMEOUT;
          end
        end
        default: ;
      endcase
    end
  end

  assign done = (state != RUN);

`ifdef TOHOST_WATCHDOG_EN
  assign timeout = (state == TIMEOUT);
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_tohost_monitor.sv
// Directed self-checking bench for tohost_monitor; expectations adapt to TOHOST_WATCHDOG_EN.
module tb_tohost_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wmask = '0;
  logic        done;
  logic        pass;
  logic [30:0] fail_id;
  logic        timeout;
  logic [31:0] cycle_count;

  int checks = 0;
  int failures = 0;

  tohost_monitor #(
    .TOHOST_ADDR   (32'h0000_1000),
    .WATCHDOG_TICKS(100)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wmask  (mem_wmask),
    .done       (done),
    .pass       (pass),
    .fail_id    (fail_id),
    .timeout    (timeout),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Reset is released on a falling edge, so the next rising edge is the first RUN cycle.
  task automatic do_reset();
    rst = 1'b1;
    mem_we = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
    mem_we    = 1'b1;
    mem_addr  = addr;
    mem_wdata = data;
    mem_wmask = mask;
    @(negedge clk);
    mem_we    = 1'b0;
    mem_wdata = '0;
    mem_wmask = '0;
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_fail_id", 32'(fail_id), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_count", cycle_count, 32'd0);

    // Pass after 20 idle cycles: store captured on edge 21
    idle(20);
    check("pre_pass_done", 32'(done), 32'd0);
    store(32'h1000, 32'd1, 4'hF);
    check("pass_done", 32'(done), 32'd1);
    check("pass_pass", 32'(pass), 32'd1);
    check("pass_fail_id", 32'(fail_id), 32'd0);
    check("pass_timeout", 32'(timeout), 32'd0);
    check("pass_count", cycle_count, 32'd21);
    idle(50);
    check("pass_hold_pass", 32'(pass), 32'd1);
    check("pass_hold_count", cycle_count, 32'd21);

    // Fail with TESTNUM 3, later pass write ignored
    do_reset();
    store(32'h1000, 32'h0000_0007, 4'hF);
    check("fail_done", 32'(done), 32'd1);
    check("fail_pass", 32'(pass), 32'd0);
    check("fail_id", 32'(fail_id), 32'd3);
    check("fail_count", cycle_count, 32'd1);
    store(32'h1000, 32'd1, 4'hF);
    check("fail_sticky_pass", 32'(pass), 32'd0);
    check("fail_sticky_id", 32'(fail_id), 32'd3);

    // Ignored stores
    do_reset();
    store(32'h1000, 32'd1, 4'h1);
    check("partial_mask_done", 32'(done), 32'd0);
    store(32'h1004, 32'd1, 4'hF);
    check("other_addr_done", 32'(done), 32'd0);
    store(32'h1000, 32'd2, 4'hF);
    check("even_value_done", 32'(done), 32'd0);
    store(32'h1000, 32'd0, 4'hF);
    check("zero_value_done", 32'(done), 32'd0);
    store(32'h1000, 32'd1, 4'hF);
    check("after_ignored_pass", 32'(pass), 32'd1);
    check("after_ignored_count", cycle_count, 32'd5);

    // Watchdog with no stores
    do_reset();
    idle(99);
    check("wd_edge_minus1_done", 32'(done), 32'd0);
    check("wd_edge_minus1_count", cycle_count, 32'd99);
    idle(1);
`ifdef TOHOST_WATCHDOG_EN
    check("wd_timeout", 32'(timeout), 32'd1);
    check("wd_done", 32'(done), 32'd1);
    check("wd_pass", 32'(pass), 32'd0);
    check("wd_count", cycle_count, 32'd100);
    idle(20);
    check("wd_count_frozen", cycle_count, 32'd100);
`else
    idle(900);
    check("nowd_done", 32'(done), 32'd0);
    check("nowd_timeout", 32'(timeout), 32'd0);
    check("nowd_count", cycle_count, 32'd1000);
`endif

    // Store in the expiry cycle wins over the watchdog
    do_reset();
    idle(99);
    store(32'h1000, 32'd1, 4'hF);
    check("race_pass", 32'(pass), 32'd1);
    check("race_timeout", 32'(timeout), 32'd0);
    check("race_done", 32'(done), 32'd1);
    check("race_count", cycle_count, 32'd100);

    // Asynchronous reset mid-clock while done
    #2;
    rst = 1'b1;
    #1;
    check("async_done", 32'(done), 32'd0);
    check("async_pass", 32'(pass), 32'd0);
    check("async_count", cycle_count, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    store(32'h1000, 32'd5, 4'hF);
    check("post_rst_fail_id", 32'(fail_id), 32'd2);
    check("post_rst_pass", 32'(pass), 32'd0);
    check("post_rst_count", cycle_count, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
